countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter and load-value width in bits.
REQ-002 Parameter TICK_DIV, default 8388608 (2^23), SHALL set the number of clk cycles between count ticks; legal range is 2 or more.
REQ-003 Port clk  input  1  SHALL be the single system clock, 50 MHz on board; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port start  input  1  SHALL be a level sampled each clk; high requests load and run.
REQ-006 Port pause  input  1  SHALL, while high in RUN, freeze the count and the prescaler.
REQ-007 Port load_val  input  WIDTH  SHALL be the start value, sampled on the cycle start is accepted.
REQ-008 Port count  output  WIDTH  SHALL be the current count, registered.
REQ-009 Port busy  output  1  SHALL be high exactly while in RUN or PAUSED.
REQ-010 Port done  output  1  SHALL be a one-clk pulse marking arrival at zero.

Function
REQ-011 States SHALL be IDLE, RUN, PAUSED and DONE.
REQ-012 The internal prescaler SHALL assert a one-cycle tick every TICK_DIV clk cycles while in RUN, and SHALL clear on every accepted start.
REQ-013 start SHALL be accepted in every state; start has priority over pause and tick.
REQ-014 On accepted start with load_val != 0: next cycle count=load_val, state RUN; the first tick SHALL arrive TICK_DIV cycles later.
REQ-015 On accepted start with load_val == 0: next cycle count=0, state DONE, done=1 for that single cycle.
REQ-016 In RUN, a tick with count > 1 SHALL decrement count by 1.
REQ-017 In RUN, a tick with count == 1 SHALL set count=0, enter DONE and pulse done in the same cycle count becomes 0.
REQ-018 RUN with pause=1 SHALL go to PAUSED; PAUSED with pause=0 SHALL return to RUN; the prescaler phase SHALL be preserved across the pause.
REQ-019 In DONE, with the auto-reload feature compiled out, count SHALL hold 0 and done SHALL stay low until the next accepted start.
REQ-020 count SHALL never wrap below 0; a decrement is never applied to 0.
REQ-021 busy SHALL be registered and change in the same cycle as the state change.

Reset
REQ-022 rst low SHALL immediately force state IDLE, count=0, done=0, busy=0 and prescaler=0, regardless of clk.
REQ-023 Reset mid-count SHALL discard the count; no done pulse SHALL be produced by reset or by its release.
REQ-024 The first cycle after rst deasserts SHALL behave as IDLE, with start honoured.

Configuration
REQ-025 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL control automatic reload.
REQ-026 With the macro defined: in DONE, the next tick SHALL set count=load_val and return to RUN when load_val != 0; when load_val == 0, the block SHALL stay in DONE with no further done pulses.
REQ-027 With the macro defined, the prescaler SHALL keep running in DONE, so the reload tick arrives TICK_DIV cycles after the done pulse.
REQ-028 Without the macro, the behaviour in REQ-019 SHALL apply and no reload logic SHALL be synthesised.

Structure
REQ-029 Package countdown_pkg SHALL hold the state enumeration type and the default WIDTH and TICK_DIV constants.
REQ-030 The prescaler SHALL be the sub-module tick_gen, with ports clk, rst, clr, en and tick, parameterised by TICK_DIV.
REQ-031 The board top level SHALL drive count onto LEDR[3:0], KEY[0] onto rst and CLOCK_50 onto clk.

Verification (bench uses WIDTH=4, TICK_DIV=4)
REQ-032 Reset, then start pulse with load_val=3 -> busy=1; count reads 3, 2, 1, 0 at 4-cycle spacing; done=1 for exactly one cycle when count=0; busy=0 thereafter.
REQ-033 Start pulse with load_val=0 -> next cycle done=1 and count=0; busy never rises.
REQ-034 load_val=5, pause held for 10 cycles after the first decrement -> count holds 4 throughout the pause; the next tick arrives at the preserved prescaler phase.
REQ-035 rst driven low while count=2 in RUN -> count=0 and busy=0 asynchronously; no done pulse.
REQ-036 Start reasserted with load_val=9 while count=6 -> count=9 next cycle; prescaler restarts; the full 9-tick sequence follows.
REQ-037 With COUNTDOWN_AUTO_RELOAD_EN defined and load_val=2 -> count reads 2, 1, 0 (done pulse), then 2 on the next tick, repeating indefinitely.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and default constants for the countdown timer.
// Optional auto-reload is selected by COUNTDOWN_AUTO_RELOAD_EN in countdown_timer.sv.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_TICK_DIV = 8388608;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: one-cycle tick after every TICK_DIV enabled clk cycles.
// clr restarts the phase; holding en low freezes it.
module tick_gen
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause and a one-cycle done pulse on reaching zero.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload load_val on the tick after DONE.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             presc_en;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign presc_en = ((state_q == RUN) && !pause) || (state_q == DONE);
`else
    assign presc_en = (state_q == RUN) && !pause;
`endif

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (presc_en),
        .tick(tick)
    );

    // start overrides pause and tick in every state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (start) begin
            if (load_val != '0) begin
                count_d = load_val;
                state_d = RUN;
            end else begin
                count_d = '0;
                state_d = DONE;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (tick && (load_val != '0)) begin
                        count_d = load_val;
                        state_d = RUN;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
        busy_d = (state_d == RUN) || (state_d == PAUSED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with WIDTH=4, TICK_DIV=4.
// Define COUNTDOWN_AUTO_RELOAD_EN to also exercise the reload sequence.
module tb_countdown_timer;

    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    int compared;
    int mismatched;

    typedef struct {
        logic             start;
        logic             pause;
        logic [WIDTH-1:0] loadVal;
        logic [WIDTH-1:0] expCount;
        logic             expBusy;
        logic             expDone;
    } vec_t;

    vec_t vecs[$];

    countdown_timer #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .load_val(load_val),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input logic s, input logic p, input logic [WIDTH-1:0] lv,
                                   input logic [WIDTH-1:0] ec, input logic eb, input logic ed);
        vec_t v;
        v.start    = s;
        v.pause    = p;
        v.loadVal  = lv;
        v.expCount = ec;
        v.expBusy  = eb;
        v.expDone  = ed;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic s, input logic p, input logic [WIDTH-1:0] lv);
        start    = s;
        pause    = p;
        load_val = lv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] ec,
                               input logic eb, input logic ed);
        compared++;
        if (count !== ec || busy !== eb || done !== ed) begin
            mismatched++;
            $display("[TB] FAIL %s: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     name, count, busy, done, ec, eb, ed);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // countdown from 3, then a zero load
        addVec(1'b1, 1'b0, 4'd3, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) addVec(1'b0, 1'b0, 4'd3, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) addVec(1'b0, 1'b0, 4'd3, 4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) addVec(1'b0, 1'b0, 4'd3, 4'd1, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0);
        addVec(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        #13;
        checkOutput("reset_state", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].pause, vecs[i].loadVal);
            step();
            checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expBusy, vecs[i].expDone);
        end

        // pause for 10 cycles right after the first decrement from 5
        applyStimulus(1'b1, 1'b0, 4'd5);
        step();
        checkOutput("pause_load", 4'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd5);
        for (int i = 0; i < 4; i++) step();
        checkOutput("pause_first_dec", 4'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput($sformatf("pause_hold%0d", i), 4'd4, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 4'd5);
        for (int i = 0; i < 4; i++) step();
        checkOutput("pause_phase_before", 4'd4, 1'b1, 1'b0);
        step();
        checkOutput("pause_phase_tick", 4'd3, 1'b1, 1'b0);

        // asynchronous reset while count=2
        applyStimulus(1'b1, 1'b0, 4'd2);
        step();
        applyStimulus(1'b0, 1'b0, 4'd2);
        step();
        checkOutput("rst_precond", 4'd2, 1'b1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("rst_async", 4'd0, 1'b0, 1'b0);
        step();
        checkOutput("rst_held", 4'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        step();
        checkOutput("rst_release", 4'd0, 1'b0, 1'b0);

        // restart at 9 while counting at 6, then the full sequence
        applyStimulus(1'b1, 1'b0, 4'd7);
        step();
        checkOutput("restart_load7", 4'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd7);
        for (int i = 0; i < 4; i++) step();
        checkOutput("restart_at6", 4'd6, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd9);
        step();
        checkOutput("restart_load9", 4'd9, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd9);
        for (int k = 1; k <= 36; k++) begin
            logic [WIDTH-1:0] ec;
            ec = WIDTH'(9 - k / 4);
            step();
            if (k == 36) checkOutput("restart_done", 4'd0, 1'b0, 1'b1);
            else         checkOutput($sformatf("restart_k%0d", k), ec, 1'b1, 1'b0);
        end
        step();
        checkOutput("restart_after", 4'd0, 1'b0, 1'b0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // reload from 2 repeats with a 12-cycle period
        applyStimulus(1'b1, 1'b0, 4'd2);
        step();
        checkOutput("reload_k0", 4'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd2);
        for (int k = 1; k < 40; k++) begin
            int ph;
            logic [WIDTH-1:0] ec;
            ph = k % 12;
            ec = (ph < 4) ? 4'd2 : (ph < 8) ? 4'd1 : 4'd0;
            step();
            checkOutput($sformatf("reload_k%0d", k), ec, (ph < 8), (ph == 8));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
